// File: rtl/uart_bus_master.sv
// rtl/uart_bus_master.sv - byte-stream command frames to single-word peripheral bus rd/wr
module uart_bus_master #(
    parameter int unsigned TIMEOUT  = 1000000,
    parameter logic [7:0]  ACK_BYTE = 8'h4B,
    parameter logic [7:0]  NAK_BYTE = 8'h3F
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        rd,
    output logic        wr,
    output logic [31:0] addr,
    output logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic        busy,
    output logic [7:0]  err_count
);

    localparam logic [7:0] CMD_WRITE = 8'h57;
    localparam logic [7:0] CMD_READ  = 8'h52;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        DATA,
        BUS_WR,
        BUS_RD,
        RESP
    } state_t;

    state_t      state, state_nxt;
    logic        is_write;
    logic [1:0]  byte_idx;
    logic [1:0]  resp_left;
    logic [31:0] rd_shift;
    logic [31:0] tmo_cnt;
    logic        in_frame;
    logic        tmo_hit;
    logic        err_inc;
    logic        tx_fire;

    assign rd       = (state == BUS_RD);
    assign wr       = (state == BUS_WR);
    assign tx_valid = (state == RESP);
    assign busy     = (state != IDLE);
    assign tx_fire  = tx_valid && tx_ready;
    assign in_frame = (state == ADDR) || (state == DATA);

    // Fires on the TIMEOUT-th consecutive idle cycle inside a frame.
    assign tmo_hit = (TIMEOUT != 0) && in_frame && !rx_valid
                     && (tmo_cnt == TIMEOUT - 32'd1);

    always_comb begin
        state_nxt = state;
        err_inc   = 1'b0;
        case (state)
            IDLE: begin
                if (rx_valid) begin
                    if (rx_data == CMD_WRITE || rx_data == CMD_READ) begin
                        state_nxt = ADDR;
                    end else begin
                        state_nxt = RESP;
                        err_inc   = 1'b1;
                    end
                end
            end
            ADDR: begin
                if (rx_valid && byte_idx == 2'd3) begin
                    state_nxt = is_write ? DATA : BUS_RD;
                end else if (tmo_hit) begin
                    state_nxt = IDLE;
                    err_inc   = 1'b1;
                end
            end
            DATA: begin
                if (rx_valid && byte_idx == 2'd3) begin
                    state_nxt = BUS_WR;
                end else if (tmo_hit) begin
                    state_nxt = IDLE;
                    err_inc   = 1'b1;
                end
            end
            BUS_WR, BUS_RD: begin
                state_nxt = RESP;
                err_inc   = rx_valid;
            end
            RESP: begin
                err_inc = rx_valid;
                if (tx_fire && resp_left == 2'd0) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            is_write  <= 1'b0;
            byte_idx  <= 2'd0;
            resp_left <= 2'd0;
            rd_shift  <= 32'd0;
            tmo_cnt   <= 32'd0;
            addr      <= 32'd0;
            wdata     <= 32'd0;
            tx_data   <= 8'd0;
            err_count <= 8'd0;
        end else begin
            state <= state_nxt;

            if (err_inc && err_count != 8'hFF) begin
                err_count <= err_count + 8'd1;
            end

            if (TIMEOUT != 0 && in_frame && !rx_valid) begin
                tmo_cnt <= tmo_cnt + 32'd1;
            end else begin
                tmo_cnt <= 32'd0;
            end

            case (state)
                IDLE: begin
                    byte_idx <= 2'd0;
                    if (rx_valid) begin
                        is_write  <= (rx_data == CMD_WRITE);
                        tx_data   <= NAK_BYTE;
                        resp_left <= 2'd0;
                    end
                end
                ADDR: begin
                    if (rx_valid) begin
                        addr     <= {addr[23:0], rx_data};
                        byte_idx <= byte_idx + 2'd1;
                    end
                end
                DATA: begin
                    if (rx_valid) begin
                        wdata    <= {wdata[23:0], rx_data};
                        byte_idx <= byte_idx + 2'd1;
                    end
                end
                BUS_WR: begin
                    tx_data   <= ACK_BYTE;
                    resp_left <= 2'd0;
                end
                BUS_RD: begin
                    tx_data   <= rdata[31:24];
                    rd_shift  <= {rdata[23:0], 8'h00};
                    resp_left <= 2'd3;
                end
                RESP: begin
                    if (tx_fire && resp_left != 2'd0) begin
                        tx_data   <= rd_shift[31:24];
                        rd_shift  <= {rd_shift[23:0], 8'h00};
                        resp_left <= resp_left - 2'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_bus_master.sv
// tb/tb_uart_bus_master.sv - scoreboard bench for uart_bus_master
module tb_uart_bus_master;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b1;
    logic        rd, wr;
    logic [31:0] addr, wdata, rdata;
    logic        busy;
    logic [7:0]  err_count;

    int total = 0;
    int bad   = 0;

    logic [7:0]  exp_tx[$];
    logic [64:0] exp_bus[$];  // {is_write, addr, wdata}

    logic        prev_stall = 1'b0;
    logic [7:0]  prev_data = 8'h00;

    always #5 clk = ~clk;

    always_comb rdata = (addr == 32'h40000010) ? 32'h12345678 : ~addr;

    uart_bus_master #(.TIMEOUT(16), .ACK_BYTE(8'h4B), .NAK_BYTE(8'h3F)) dut (
        .clk       (clk),
        .reset     (reset),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .rd        (rd),
        .wr        (wr),
        .addr      (addr),
        .wdata     (wdata),
        .rdata     (rdata),
        .busy      (busy),
        .err_count (err_count)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic flag(input string name);
        total++;
        bad++;
        $display("FAIL %s: got event expected none", name);
    endtask

    // Monitor: compares every tx handshake and bus strobe against the queues.
    always @(negedge clk) begin
        if (!reset) begin
            prev_stall <= 1'b0;
        end else begin
            if (rd && wr) flag("rd_wr_together");
            if (tx_valid && prev_stall) check("tx_hold", {24'd0, tx_data}, {24'd0, prev_data});
            if (tx_valid && tx_ready) begin
                if (exp_tx.size() == 0) flag("unexpected_tx");
                else check("tx_byte", {24'd0, tx_data}, {24'd0, exp_tx.pop_front()});
            end
            if (rd || wr) begin
                if (exp_bus.size() == 0) begin
                    flag("unexpected_bus");
                end else begin
                    logic [64:0] e;
                    e = exp_bus.pop_front();
                    check("bus_kind", {31'd0, wr}, {31'd0, e[64]});
                    check("bus_addr", addr, e[63:32]);
                    if (wr) check("bus_wdata", wdata, e[31:0]);
                end
            end
            prev_stall <= tx_valid && !tx_ready;
            prev_data  <= tx_data;
        end
    end

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk);
        #1 rx_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 3; i >= 0; i--) send_byte(w[i*8 +: 8]);
    endtask

    task automatic write_frame(input logic [31:0] a, input logic [31:0] d);
        exp_bus.push_back({1'b1, a, d});
        exp_tx.push_back(8'h4B);
        send_byte(8'h57);
        send_word(a);
        send_word(d);
        check("wr_latency", {31'd0, wr}, 32'd1);
        @(posedge clk);
        #1 check("wr_tx_latency", {31'd0, tx_valid}, 32'd1);
    endtask

    task automatic read_frame(input logic [31:0] a, input logic [31:0] r);
        exp_bus.push_back({1'b0, a, 32'd0});
        for (int i = 3; i >= 0; i--) exp_tx.push_back(r[i*8 +: 8]);
        send_byte(8'h52);
        send_word(a);
        check("rd_latency", {31'd0, rd}, 32'd1);
        @(posedge clk);
        #1 check("rd_tx_latency", {31'd0, tx_valid}, 32'd1);
    endtask

    task automatic wait_done();
        int n = 0;
        while ((busy || exp_tx.size() != 0) && n < 300) begin
            @(posedge clk);
            #1 n++;
        end
        if (n >= 300) flag("wait_done_timeout");
        check("busy_idle", {31'd0, busy}, 32'd0);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_rd"},      {31'd0, rd},       32'd0);
        check({tag, "_wr"},      {31'd0, wr},       32'd0);
        check({tag, "_addr"},    addr,              32'd0);
        check({tag, "_wdata"},   wdata,             32'd0);
        check({tag, "_txvalid"}, {31'd0, tx_valid}, 32'd0);
        check({tag, "_txdata"},  {24'd0, tx_data},  32'd0);
        check({tag, "_busy"},    {31'd0, busy},     32'd0);
        check({tag, "_err"},     {24'd0, err_count}, 32'd0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 check_reset_values("reset");
        reset = 1'b1;
        @(posedge clk);
        #1;

        write_frame(32'h4000000C, 32'h000000A5);
        wait_done();

        read_frame(32'h40000010, 32'h12345678);
        wait_done();

        // Backpressure: five stalled cycles before each response byte.
        tx_ready = 1'b0;
        read_frame(32'h40000010, 32'h12345678);
        for (int k = 0; k < 4; k++) begin
            int n = 0;
            while (!tx_valid && n < 50) begin
                @(posedge clk);
                #1 n++;
            end
            if (n >= 50) flag("stall_wait_timeout");
            repeat (5) @(posedge clk);
            #1 tx_ready = 1'b1;
            @(posedge clk);
            #1 tx_ready = 1'b0;
        end
        tx_ready = 1'b1;
        wait_done();

        // Bad command, then a byte dropped while the NAK is stalled.
        tx_ready = 1'b0;
        exp_tx.push_back(8'h3F);
        send_byte(8'hFF);
        check("nak_err1", {24'd0, err_count}, 32'd1);
        send_byte(8'h11);
        check("drop_err2", {24'd0, err_count}, 32'd2);
        repeat (2) @(posedge clk);
        #1 tx_ready = 1'b1;
        wait_done();

        // Timeout mid-address.
        send_byte(8'h57);
        send_byte(8'h40);
        repeat (12) @(posedge clk);
        #1 check("tmo_still_busy", {31'd0, busy}, 32'd1);
        repeat (8) @(posedge clk);
        #1 check("tmo_idle", {31'd0, busy}, 32'd0);
        check("tmo_err3", {24'd0, err_count}, 32'd3);
        write_frame(32'h40000014, 32'hDEADBEEF);
        wait_done();

        // Reset in the middle of the data field.
        send_byte(8'h57);
        send_word(32'h40000018);
        send_byte(8'h11);
        reset = 1'b0;
        #1 check_reset_values("midreset");
        @(posedge clk);
        #1 reset = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        read_frame(32'h40000020, 32'hBFFFFFDF);
        wait_done();

        repeat (3) @(posedge clk);
        #1 check("tx_queue_empty", exp_tx.size(), 32'd0);
        check("bus_queue_empty", exp_bus.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
